// File: rtl/rom_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// rom_stream_pkg
// Shared definitions for the ROM stream reader slice:
//   - default address/data widths and output buffer depth
//   - sequencer state encoding (IDLE / ISSUE / DRAIN)
//   - occupancy counter width helper (holds 0..depth inclusive)
// -----------------------------------------------------------------------------
package rom_stream_pkg;

   localparam int ADDR_W_DEF     = 8;
   localparam int DATA_W_DEF     = 8;
   localparam int FIFO_DEPTH_DEF = 4;

   // Occupancy counters must represent "completely full", hence the extra bit.
   localparam int CNT_W = $clog2(FIFO_DEPTH_DEF) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Counter width for an arbitrary buffer depth (same rule as CNT_W).
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/rom_stream_reader_if.sv
// -----------------------------------------------------------------------------
// rom_stream_if
// valid/ready stream carrying ROM read data downstream.
//   valid : data word present (driven by master)
//   data  : DATA_W payload     (driven by master)
//   ready : sink accepts       (driven by slave)
// A beat transfers in any cycle where valid and ready are both high.
// -----------------------------------------------------------------------------
interface rom_stream_if
   import rom_stream_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) ();

   logic              valid;
   logic [DATA_W-1:0] data;
   logic              ready;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/rom_stream_reader_fifo.sv
// -----------------------------------------------------------------------------
// rom_stream_fifo
// Synchronous FIFO whose head sits in a dedicated output register, so rd_data
// and the not-empty indication come straight from flops.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : push wr_data (may coincide with a pop when full)
//   wr_data    : WIDTH-bit write data
//   rd_en      : pop the head (ignored when empty)
//   rd_data    : registered head word, stable until popped
//   full       : count == DEPTH
//   empty      : count == 0
//   count      : number of stored words, head included
// Storage: one head register plus DEPTH-1 body entries. A write into an empty
// body that coincides with a free head bypasses straight into the head.
// -----------------------------------------------------------------------------
module rom_stream_fifo
   import rom_stream_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF,
   parameter int WIDTH = DATA_W_DEF,
   localparam int CW   = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam int BODY = DEPTH - 1;
   localparam int PW   = (BODY > 1) ? $clog2(BODY) : 1;

   logic [WIDTH-1:0] body [BODY];
   logic [PW-1:0]    head_q, tail_q;
   logic [CW-1:0]    count_q;
   logic             q_valid_q;
   logic [WIDTH-1:0] q_data_q;

   logic          pop;
   logic [CW-1:0] body_cnt;
   logic          body_empty;
   logic          q_load;
   logic          bypass;
   logic          body_push;
   logic          body_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(BODY - 1)) ? '0 : p + PW'(1);
   endfunction

   // NOTE: every signal driven here gets a default before any condition;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      pop        = 1'b0;
      body_cnt   = '0;
      body_empty = 1'b1;
      q_load     = 1'b0;
      bypass     = 1'b0;
      body_push  = 1'b0;
      body_pop   = 1'b0;

      pop        = rd_en & q_valid_q;
      body_cnt   = count_q - CW'(q_valid_q);
      body_empty = (body_cnt == '0);
      // Head register can take a new word when empty or being popped.
      q_load     = ~q_valid_q | pop;
      bypass     = q_load & body_empty & wr_en;
      body_push  = wr_en & ~bypass;
      body_pop   = q_load & ~body_empty;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         q_valid_q <= 1'b0;
         q_data_q  <= '0;
      end else begin
         if (q_load) begin
            if (!body_empty) begin
               q_data_q  <= body[head_q];
               q_valid_q <= 1'b1;
            end else if (wr_en) begin
               q_data_q  <= wr_data;
               q_valid_q <= 1'b1;
            end else begin
               q_valid_q <= 1'b0;
            end
         end

         if (body_pop)  head_q <= ptr_inc(head_q);
         if (body_push) tail_q <= ptr_inc(tail_q);

         unique case ({wr_en, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: the body array carries no reset; occupancy is tracked by the reset
   // pointers and count, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (body_push) body[tail_q] <= wr_data;
   end

   assign rd_data = q_data_q;
   assign empty   = ~q_valid_q;
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;

endmodule

// File: rtl/rom_stream_reader.sv
// -----------------------------------------------------------------------------
// rom_stream_reader
// Address sequencer in front of a ROM with RD_LAT cycles of read latency.
// A start command sweeps base_addr .. base_addr+length-1 (wrapping modulo
// 2^ADDR_W) onto rom_addr and streams the returned words downstream.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : command strobe, sampled only while idle
//   base_addr  : first address of the window (latched on start)
//   length     : number of words 0..2^ADDR_W (latched on start)
//   busy       : command in progress (cycle after start .. done)
//   done       : one-cycle end-of-command pulse
//   rom_addr   : registered ROM address
//   rom_dout   : ROM read data
//   m          : valid/ready output stream (master side)
// Parameters: RD_LAT in 0..2; FIFO_DEPTH a power of two >= RD_LAT+2.
// Flow control: an address is only issued when the buffer is guaranteed a
// slot for it, counting words already buffered plus reads still in flight,
// so backpressure can never drop a read.
// -----------------------------------------------------------------------------
module rom_stream_reader
   import rom_stream_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_dout,
   rom_stream_if.master      m
);

   localparam int CW = cnt_width(FIFO_DEPTH);
   localparam int OW = CW + 1;
   localparam int RW = ADDR_W + 1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [RW-1:0]     remain_q, remain_d;     // addresses still to issue
   logic              addr_valid_q, addr_valid_d;  // rom_addr is a real read
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // tag[0] marks the read presented this cycle; tag[i] marks the read
   // presented i cycles ago. tag[RD_LAT] is the one whose data is on rom_dout.
   logic [RD_LAT:0]   tag;
   logic [CW-1:0]     in_flight;

   logic              fifo_wr;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [DATA_W-1:0] fifo_rd_data;
   logic              pop;
   logic [OW-1:0]     occupancy;
   logic              credit_ok;
   logic              drain_done;

   generate
      if (RD_LAT == 0) begin : g_no_lat
         assign tag = addr_valid_q;
      end else begin : g_lat
         logic [RD_LAT-1:0] sr_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sr_q <= '0;
            end else begin
               sr_q[0] <= addr_valid_q;
               for (int i = 1; i < RD_LAT; i++) sr_q[i] <= sr_q[i-1];
            end
         end
         assign tag = {sr_q, addr_valid_q};
      end
   endgenerate

   assign fifo_wr = tag[RD_LAT];

   rom_stream_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (fifo_wr),
      .wr_data (rom_dout),
      .rd_en   (m.ready),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign m.valid = ~fifo_empty;
   assign m.data  = fifo_rd_data;
   assign pop     = ~fifo_empty & m.ready;

   always_comb begin
      in_flight  = '0;
      occupancy  = '0;
      credit_ok  = 1'b0;
      drain_done = 1'b0;

      for (int i = 0; i <= RD_LAT; i++) in_flight = in_flight + CW'(tag[i]);

      // A pop at this edge frees a slot before the next address lands, which
      // is what keeps a minimum-depth buffer streaming at one word per cycle.
      occupancy  = OW'(fifo_count) + OW'(in_flight) - OW'(pop);
      credit_ok  = (occupancy < OW'(FIFO_DEPTH)) & ~(fifo_full & ~pop);

      // Last beat is leaving (or already gone) and nothing else is coming.
      drain_done = (in_flight == '0) &&
                   (fifo_empty || ((fifo_count == CW'(1)) && pop));
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      remain_d     = remain_q;
      addr_valid_d = 1'b0;
      busy_d       = busy_q;
      done_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (length != '0) begin
                  state_d      = ISSUE;
                  addr_d       = base_addr;
                  remain_d     = length - RW'(1);
                  addr_valid_d = 1'b1;
                  busy_d       = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         ISSUE: begin
            if (remain_q == '0) begin
               state_d = DRAIN;
            end else if (credit_ok) begin
               addr_d       = addr_q + ADDR_W'(1);
               addr_valid_d = 1'b1;
               remain_d     = remain_q - RW'(1);
               if (remain_q == RW'(1)) state_d = DRAIN;
            end
         end

         DRAIN: begin
            if (drain_done) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         remain_q     <= '0;
         addr_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         remain_q     <= remain_d;
         addr_valid_q <= addr_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign rom_addr = addr_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_rom_stream_reader
// Three readers (RD_LAT = 0, 1, 2, FIFO_DEPTH = 4) share command inputs and
// m_ready; each has its own ROM model (mem[a] = a ^ 8'h5A) and scoreboard.
// Commands push the expected word list per instance; a negedge monitor per
// instance pops and compares on every handshake and checks hold stability.
// -----------------------------------------------------------------------------
module tb_rom_stream_reader;
   import rom_stream_pkg::*;

   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] base_addr = '0;
   logic [8:0] length = '0;
   logic       m_ready = 1'b0;

   logic [NI-1:0]      busy, done, m_valid_w;
   logic [NI-1:0][7:0] rom_addr_w, rom_dout_w, m_data_w;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   logic [7:0] exp_q    [NI][$];
   int         beat_log [NI][$];
   int         cmd_n0   [NI];
   int         done_c   [NI];
   int         cmd_s;
   logic [7:0] addr_seen [NI][9];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] rom_val(input logic [7:0] a);
      return a ^ 8'h5A;
   endfunction

   function automatic logic drive_ready(input int mode);
      if (mode == 0) return 1'b1;
      if (mode == 1) return 1'($urandom_range(0, 1));
      return 1'b0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   generate
      for (genvar g = 0; g < NI; g++) begin : g_inst
         rom_stream_if #(.DATA_W(8)) sif ();
         logic [7:0] pipe0, pipe1;
         logic       held;
         logic [7:0] held_data;

         assign sif.ready     = m_ready;
         assign m_valid_w[g]  = sif.valid;
         assign m_data_w[g]   = sif.data;

         always @(posedge clk) begin
            pipe0 <= rom_val(rom_addr_w[g]);
            pipe1 <= pipe0;
         end
         assign rom_dout_w[g] = (g == 0) ? rom_val(rom_addr_w[g]) :
                                (g == 1) ? pipe0 : pipe1;

         rom_stream_reader #(
            .ADDR_W     (8),
            .DATA_W     (8),
            .RD_LAT     (g),
            .FIFO_DEPTH (4)
         ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start),
            .base_addr (base_addr),
            .length    (length),
            .busy      (busy[g]),
            .done      (done[g]),
            .rom_addr  (rom_addr_w[g]),
            .rom_dout  (rom_dout_w[g]),
            .m         (sif)
         );

         initial held = 1'b0;

         always @(negedge clk) begin
            if (!rst_n) begin
               held = 1'b0;
            end else begin
               if (held) begin
                  check($sformatf("L%0d hold_valid", g), 32'(m_valid_w[g]), 32'd1);
                  check($sformatf("L%0d hold_data", g), 32'(m_data_w[g]), 32'(held_data));
               end
               if (m_valid_w[g] && m_ready) begin
                  if (exp_q[g].size() == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL L%0d unexpected_beat: got data 0x%0h, expected no beat (cycle %0d)",
                              g, m_data_w[g], cyc);
                  end else begin
                     check($sformatf("L%0d beat_data", g), 32'(m_data_w[g]), 32'(exp_q[g].pop_front()));
                  end
                  beat_log[g].push_back(cyc);
                  held = 1'b0;
               end else begin
                  held      = m_valid_w[g];
                  held_data = m_data_w[g];
               end
            end
         end
      end
   endgenerate

   // Issue one command and follow it to done on every instance.
   // mode: 0 m_ready=1, 1 random, 2 held low until cycle 'hold'.
   // bogus_at: cycle offset of an extra start that must be ignored.
   task automatic run_cmd(input logic [7:0] base, input int len, input int mode,
                          input int hold, input int bogus_at);
      int         rm;
      logic [7:0] a;
      bit         all_done;
      rm = mode;
      for (int g = 0; g < NI; g++) begin
         cmd_n0[g] = beat_log[g].size();
         done_c[g] = -1;
      end
      for (int i = 0; i < len; i++) begin
         a = base + 8'(i);
         for (int g = 0; g < NI; g++) exp_q[g].push_back(rom_val(a));
      end
      base_addr = base;
      length    = 9'(len);
      start     = 1'b1;
      m_ready   = drive_ready(rm);
      cmd_s     = cyc;
      for (int k = 1; k <= 3000; k++) begin
         tick();
         start     = (k == bogus_at);
         base_addr = 8'($urandom);
         length    = 9'($urandom_range(1, 256));
         all_done  = 1'b1;
         for (int g = 0; g < NI; g++) begin
            if (k <= 8) addr_seen[g][k] = rom_addr_w[g];
            if (done_c[g] < 0) begin
               if (done[g]) begin
                  done_c[g] = cyc;
                  check($sformatf("L%0d busy_at_done", g), 32'(busy[g]), 32'd0);
               end else begin
                  check($sformatf("L%0d busy_during", g), 32'(busy[g]), 32'(len != 0));
               end
            end
            if (done_c[g] < 0) all_done = 1'b0;
         end
         if (hold > 0 && k == hold) begin
            for (int g = 0; g < NI; g++) begin
               check($sformatf("L%0d stall_addr", g), 32'(rom_addr_w[g]), 32'(base + 8'd3));
               check($sformatf("L%0d stall_valid", g), 32'(m_valid_w[g]), 32'd1);
            end
            rm = 0;
         end
         m_ready = drive_ready(rm);
         if (all_done) break;
      end
      start = 1'b0;
      for (int g = 0; g < NI; g++) begin
         if (done_c[g] < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL L%0d done_timeout: got no done pulse, expected one within 3000 cycles", g);
         end
         check($sformatf("L%0d leftover_words", g), 32'(exp_q[g].size()), 32'd0);
         check($sformatf("L%0d beat_count", g), 32'(beat_log[g].size() - cmd_n0[g]), 32'(len));
      end
      tick();
      for (int g = 0; g < NI; g++)
         check($sformatf("L%0d done_pulse_width", g), 32'(done[g]), 32'd0);
   endtask

   // Timing expectations for a command run with m_ready held high.
   task automatic check_fast(input int len);
      for (int g = 0; g < NI; g++) begin
         if (len == 0) begin
            check($sformatf("L%0d done_cycle_len0", g), 32'(done_c[g]), 32'(cmd_s + 1));
         end else begin
            check($sformatf("L%0d done_cycle", g), 32'(done_c[g]), 32'(cmd_s + 2 + g + len));
            if (beat_log[g].size() > cmd_n0[g]) begin
               check($sformatf("L%0d first_beat_cycle", g), 32'(beat_log[g][cmd_n0[g]]),
                     32'(cmd_s + 2 + g));
               check($sformatf("L%0d last_beat_cycle", g), 32'(beat_log[g][$]),
                     32'(cmd_s + 1 + g + len));
            end
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag_s);
      for (int g = 0; g < NI; g++) begin
         check($sformatf("%s L%0d busy", tag_s, g), 32'(busy[g]), 32'd0);
         check($sformatf("%s L%0d done", tag_s, g), 32'(done[g]), 32'd0);
         check($sformatf("%s L%0d m_valid", tag_s, g), 32'(m_valid_w[g]), 32'd0);
         check($sformatf("%s L%0d m_data", tag_s, g), 32'(m_data_w[g]), 32'd0);
         check($sformatf("%s L%0d rom_addr", tag_s, g), 32'(rom_addr_w[g]), 32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] b;
      int         l;

      #3;
      check_reset_outputs("reset");
      tick();
      rst_n = 1'b1;
      tick();

      // Directed: base 0x10, 4 words, full-rate sink.
      run_cmd(8'h10, 4, 0, 0, -1);
      check_fast(4);

      // Window crossing 0xFF.
      run_cmd(8'hFE, 4, 0, 0, -1);
      check_fast(4);
      for (int g = 0; g < NI; g++) begin
         check($sformatf("L%0d wrap_addr1", g), 32'(addr_seen[g][1]), 32'hFE);
         check($sformatf("L%0d wrap_addr2", g), 32'(addr_seen[g][2]), 32'hFF);
         check($sformatf("L%0d wrap_addr3", g), 32'(addr_seen[g][3]), 32'h00);
         check($sformatf("L%0d wrap_addr4", g), 32'(addr_seen[g][4]), 32'h01);
      end

      // Backpressure: sink stalled for 20 cycles, then released.
      run_cmd(8'($urandom), 16, 2, 20, -1);

      // Zero-length command.
      run_cmd(8'($urandom), 0, 0, 0, -1);
      check_fast(0);

      // Start pulsed mid-burst must be ignored.
      run_cmd(8'($urandom), 16, 0, 0, 3);
      check_fast(16);

      // Full 256-word sweep at full rate.
      run_cmd(8'($urandom), 256, 0, 0, -1);
      check_fast(256);

      // Random commands with a random sink.
      for (int n = 0; n < 6; n++) begin
         b = 8'($urandom);
         l = $urandom_range(1, 40);
         run_cmd(b, l, 1, 0, -1);
      end

      // Asynchronous reset in the middle of a burst.
      b = 8'($urandom);
      for (int i = 0; i < 64; i++)
         for (int g = 0; g < NI; g++) exp_q[g].push_back(rom_val(b + 8'(i)));
      base_addr = b;
      length    = 9'd64;
      start     = 1'b1;
      for (int k = 0; k < 10; k++) begin
         m_ready = drive_ready(1);
         tick();
         start = 1'b0;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      for (int g = 0; g < NI; g++) exp_q[g].delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      run_cmd(8'h33, 8, 0, 0, -1);
      check_fast(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
